// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing for ArqMIPS32: load-use bubbles, taken-branch flushes and data-memory freezes.
// Optional stall-cycle performance counter is built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int ADDR_SIZE = 5,
  parameter int WAIT_MAX  = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE-1:0] id_rs,
  input  logic [ADDR_SIZE-1:0] id_rt,
  input  logic                 ex_mem_read,
  input  logic [ADDR_SIZE-1:0] ex_rt,
  input  logic                 br_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_en,
  output logic                 mem_wb_en,
  output logic                 timeout,
  output logic [31:0]          stall_cycles,
  output logic [1:0]           fsm_state
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  // Handshake: mem_req/mem_ready form a single-cycle completion protocol; an access
  // completes on the cycle mem_ready is high, otherwise the whole pipe holds.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          flush_pend;
  logic          timeout_q;
  logic          hazard;
  logic          mem_stall;

  assign hazard    = ex_mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign mem_stall = mem_req && !mem_ready;
  assign timeout   = timeout_q;
  assign fsm_state = state;

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    case (state)
      RUN: begin
        if (mem_stall) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end else if (br_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (hazard) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end
      end
      FLUSH: begin
        if (mem_stall) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end else begin
          id_ex_flush = 1'b1;
        end
      end
      default: begin
        pc_en = 1'b1;
      end
    endcase
  end

  // A flush interrupted by a memory stall resumes through FLUSH once the access completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      wait_cnt   <= '0;
      flush_pend <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state      <= MEM_WAIT;
            wait_cnt   <= CW'(1);
            flush_pend <= 1'b0;
            if (CW'(WAIT_MAX) == CW'(1)) timeout_q <= 1'b1;
          end else if (br_taken) begin
            state <= FLUSH;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state      <= flush_pend ? FLUSH : RUN;
            wait_cnt   <= '0;
            flush_pend <= 1'b0;
          end else begin
            if (wait_cnt != CW'(WAIT_MAX)) wait_cnt <= wait_cnt + CW'(1);
            if (wait_cnt >= CW'(WAIT_MAX - 1)) timeout_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (mem_stall) begin
            state      <= MEM_WAIT;
            wait_cnt   <= CW'(1);
            flush_pend <= 1'b1;
            if (CW'(WAIT_MAX) == CW'(1)) timeout_q <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (!pc_en) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
